hash_lookup: RTL and testbench
==============================

Name: hash_lookup

Overview:
- Initiator/reader side of the 8-entry hash ROM interface.
- Drives the ROM address and consumes the 32-bit ROM data word.
- Accepts a 32-bit candidate key via valid/ready. Scans ROM entries 0..DEPTH-1, one per cycle, and reports hit/miss plus the matching index.
- Sits between the candidate generator and the asynchronous-read hash ROM in the hash-check datapath.

Parameters:
- ADDR_W, 3, ROM address width.
- DATA_W, 32, key / ROM word width.
- DEPTH, 8, number of ROM entries scanned; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  key presented.
- start_ready  out  1  block can accept a key.
- key  in  DATA_W  candidate hash; sampled on accept.
- rom_addr  out  ADDR_W  address to ROM; registered.
- rom_data  in  DATA_W  ROM word, combinational from rom_addr in the same cycle.
- done  out  1  one-cycle pulse when the result is valid.
- hit  out  1  1 = key found.
- hit_idx  out  ADDR_W  index of the match; 0 on miss.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, start_ready=0, rom_addr=0, done=0, hit=0, hit_idx=0, internal key register=0.
  - start_ready rises the first clk edge after rst_n deasserts.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start_ready=1.
  - Accept = start_valid & start_ready at an edge. On accept: latch key into key_q, rom_addr←0, clear hit/hit_idx, go to SCAN.
- SCAN:
  - start_ready=0; start_valid is ignored.
  - Each cycle compare rom_data against key_q (full DATA_W equality).
  - On equal: hit←1, hit_idx←rom_addr, go to DONE.
  - Else if rom_addr==DEPTH-1: hit←0, hit_idx←0, go to DONE.
  - Else rom_addr←rom_addr+1.
  - rom_addr never wraps within a scan.
- DONE:
  - done=1 for exactly one cycle; start_ready=0.
  - Next edge goes to IDLE and rom_addr←0.
  - hit/hit_idx stay stable until the next accept.
- Latency, counted from the accept edge to the first cycle with done high:
  - match at index i: i+1 cycles;
  - miss: DEPTH cycles.
- Throughput: a new key is accepted no sooner than one cycle after done.
- Duplicate ROM entries: the lowest index wins.
- Reset mid-SCAN or mid-DONE: immediate return to the reset values above; no done pulse.
- key changing after accept has no effect.

Optional Feature:
- Macro: HASH_LOOKUP_COUNT_EN.
- Defined:
  - Adds output hit_cnt [ADDR_W:0].
  - SCAN never exits early; it always visits all DEPTH entries.
  - hit_cnt counts matches and is cleared on accept.
  - hit=(hit_cnt!=0); hit_idx = lowest matching index.
  - Latency is always DEPTH cycles.
- Undefined: no hit_cnt port; early exit as specified above.

Decomposition:
- Shared package hash_pkg holds:
  - HASH_ADDR_W=3, HASH_DATA_W=32, HASH_DEPTH=8;
  - typedef hash_word_t (logic [31:0]);
  - typedef hash_idx_t (logic [2:0]);
  - enum lookup_state_t {IDLE, SCAN, DONE}.
- No sub-module: the ROM is instantiated alongside by the parent, and the FSM and comparator are small enough to stay inline.

Test Plan:
1. Reset release, no start_valid: start_ready=1 one edge after rst_n=1; done=0, hit=0, hit_idx=0, rom_addr=0.
2. key=32'hDC1A2C9E, ROM entry 0 → done 1 cycle after accept, hit=1, hit_idx=0.
3. key=32'h9948E6BE, entry 7 → done 8 cycles after accept, hit=1, hit_idx=7; rom_addr stepped 0..7 with no wrap.
4. key=32'h12345678, absent → done after 8 cycles, hit=0, hit_idx=0. Hold start_valid=1 with a new key during SCAN → no second accept and no change to key_q.
5. key=32'hAAF4ADC9, entry 3; pull rst_n low when rom_addr=2 → outputs reset asynchronously and no done pulse. After release, key=32'hAAF4ADC9 → hit=1, hit_idx=3, latency 4.
6. With HASH_LOOKUP_COUNT_EN, ROM entries 2 and 5 both set to 32'h355FACC3, key=32'h355FACC3 → done at 8 cycles, hit_cnt=2, hit_idx=2, hit=1.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared types and sizes for the hash-check datapath.
package hash_pkg;

  localparam int unsigned HASH_ADDR_W = 3;
  localparam int unsigned HASH_DATA_W = 32;
  localparam int unsigned HASH_DEPTH  = 8;

  typedef logic [HASH_DATA_W-1:0] hash_word_t;
  typedef logic [HASH_ADDR_W-1:0] hash_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } lookup_state_t;

endpackage

// File: rtl/hash_lookup.sv
// Reader side of the hash ROM: accepts a key, scans ROM entries 0..DEPTH-1 one per cycle
// and reports hit/miss with the matching index.
// Optional: define HASH_LOOKUP_COUNT_EN to scan every entry and count matches on hit_cnt.
module hash_lookup
  import hash_pkg::*;
#(
  parameter int unsigned ADDR_W = HASH_ADDR_W,
  parameter int unsigned DATA_W = HASH_DATA_W,
  parameter int unsigned DEPTH  = HASH_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] key,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              done,
  output logic              hit,
`ifdef HASH_LOOKUP_COUNT_EN
  output logic [ADDR_W:0]   hit_cnt,
`endif
  output logic [ADDR_W-1:0] hit_idx
);

  lookup_state_t     state_q, state_d;
  logic [DATA_W-1:0] key_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              hit_q;
  logic [ADDR_W-1:0] hit_idx_q;
  // Holds start_ready low until the first edge after reset release.
  logic              ready_q;
`ifdef HASH_LOOKUP_COUNT_EN
  logic [ADDR_W:0]   cnt_q;
`endif

  logic accept;
  logic match;
  logic last;

  assign accept = start_valid & start_ready;
  assign match  = (rom_data == key_q);
  assign last   = (rom_addr_q == ADDR_W'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SCAN;
`ifdef HASH_LOOKUP_COUNT_EN
      SCAN: if (last) state_d = DONE;
`else
      SCAN: if (match || last) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and result-strobe outputs.
  always_comb begin
    start_ready = ready_q && (state_q == IDLE);
    done        = (state_q == DONE);
  end

  // Key, address and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      key_q      <= '0;
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
`ifdef HASH_LOOKUP_COUNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            key_q      <= key;
            rom_addr_q <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
`ifdef HASH_LOOKUP_COUNT_EN
            cnt_q      <= '0;
`endif
          end
        end
        SCAN: begin
`ifdef HASH_LOOKUP_COUNT_EN
          if (match) begin
            cnt_q <= cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            // First match seen keeps the lowest index.
            if (!hit_q) begin
              hit_q     <= 1'b1;
              hit_idx_q <= rom_addr_q;
            end
          end
          if (!last) rom_addr_q <= rom_addr_q + ADDR_W'(1);
`else
          if (match) begin
            hit_q     <= 1'b1;
            hit_idx_q <= rom_addr_q;
          end else if (last) begin
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
          end else begin
            rom_addr_q <= rom_addr_q + ADDR_W'(1);
          end
`endif
        end
        DONE: rom_addr_q <= '0;
        default: ;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign hit      = hit_q;
  assign hit_idx  = hit_idx_q;
`ifdef HASH_LOOKUP_COUNT_EN
  assign hit_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_hash_lookup.sv
// Scoreboard bench for hash_lookup: the driver pushes expected results on accept, the monitor
// pops and compares on every done pulse.
module tb_hash_lookup;
  import hash_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] key = '0;
  logic [2:0]  rom_addr;
  logic [31:0] rom_data;
  logic        done;
  logic        hit;
  logic [2:0]  hit_idx;
`ifdef HASH_LOOKUP_COUNT_EN
  logic [3:0]  hit_cnt;
`endif

  logic [31:0] rom [8];
  assign rom_data = rom[rom_addr];

  typedef struct {
    logic       hit;
    logic [2:0] idx;
    int         cyc;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  hash_lookup dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key         (key),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .done        (done),
    .hit         (hit),
`ifdef HASH_LOOKUP_COUNT_EN
    .hit_cnt     (hit_cnt),
`endif
    .hit_idx     (hit_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic ehit, input logic [2:0] eidx);
`ifdef HASH_LOOKUP_COUNT_EN
    return 8;
`else
    return ehit ? int'(eidx) + 1 : 8;
`endif
  endfunction

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hit", {31'd0, hit}, {31'd0, e.hit});
        chk("hit_idx", {29'd0, hit_idx}, {29'd0, e.idx});
        chk("latency", cyc, e.cyc);
`ifdef HASH_LOOKUP_COUNT_EN
        chk("hit_cnt", {28'd0, hit_cnt}, {28'd0, e.cnt});
`endif
      end
    end
    prev_done <= done;
  end

  // Present a key, wait for acceptance and record the expected result.
  task automatic issue(input logic [31:0] k, input logic ehit, input logic [2:0] eidx,
                       input logic [3:0] ecnt);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!start_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got start_ready=0, expected 1 within 20 cycles");
    end
    key = k;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    chk("accepted", {31'd0, start_ready}, 32'd0);
    e.hit = ehit;
    e.idx = eidx;
    e.cyc = cyc + exp_lat(ehit, eidx);
    e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got done=0, expected a pulse within 40 cycles");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rom[0] = 32'hDC1A2C9E;
    rom[1] = 32'h01234567;
    rom[2] = 32'h89ABCDEF;
    rom[3] = 32'hAAF4ADC9;
    rom[4] = 32'h0F0F0F0F;
    rom[5] = 32'hF0F0F0F0;
    rom[6] = 32'h13579BDF;
    rom[7] = 32'h9948E6BE;

    // 1: reset values and ready one edge after release.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", {31'd0, start_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, start_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", {31'd0, start_ready}, 32'd1);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_hit", {31'd0, hit}, 32'd0);
    chk("idle_hit_idx", {29'd0, hit_idx}, 32'd0);
    chk("idle_rom_addr", {29'd0, rom_addr}, 32'd0);

    // 2: match at entry 0.
    issue(32'hDC1A2C9E, 1'b1, 3'd0, 4'd1);
    wait_done();

    // 3: match at entry 7, address walks 0..7.
    issue(32'h9948E6BE, 1'b1, 3'd7, 4'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("scan_addr", {29'd0, rom_addr}, k);
    end
    wait_done();

    // 4: miss, with a new valid key held throughout the scan.
    issue(32'h12345678, 1'b0, 3'd0, 4'd0);
    key = 32'hDC1A2C9E;
    start_valid = 1'b1;
    wait_done();
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_second_accept", exp_q.size(), 32'd0);

    // 5: reset while scanning address 2, then retry.
    issue(32'hAAF4ADC9, 1'b1, 3'd3, 4'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rom_addr == 3'd2) break;
    end
    chk("reached_addr2", {29'd0, rom_addr}, 32'd2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_ready", {31'd0, start_ready}, 32'd0);
    chk("mid_rst_addr", {29'd0, rom_addr}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_hit", {31'd0, hit}, 32'd0);
    chk("mid_rst_hit_idx", {29'd0, hit_idx}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(32'hAAF4ADC9, 1'b1, 3'd3, 4'd1);
    wait_done();

`ifdef HASH_LOOKUP_COUNT_EN
    // 6: duplicate entries, count both and keep the lowest index.
    rom[2] = 32'h355FACC3;
    rom[5] = 32'h355FACC3;
    issue(32'h355FACC3, 1'b1, 3'd2, 4'd2);
    wait_done();
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
